// File: rtl/audio_sdram_loader_if.sv
// audio_sdram_loader_if
//   Byte-stream intake and SDRAM write handshake used by audio_sdram_loader.
//   master : the loader side. It takes bytes in and drives SDRAM write requests.
//   slave  : the environment side, i.e. the SPI/SD byte reader plus the SDRAM controller.
//   Signals:
//     byte_valid/byte_data/byte_ready      byte stream, low byte of each sample first
//     sdram_Wait/sdram_ac                  controller busy / write acknowledge
//     sdram_wr/sdram_addr/sdram_wdata      write request, address, data
interface audio_sdram_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        sdram_Wait;
    logic        sdram_ac;
    logic        sdram_wr;
    logic [24:0] sdram_addr;
    logic [15:0] sdram_wdata;

    modport master (
        input  byte_valid, byte_data, sdram_Wait, sdram_ac,
        output byte_ready, sdram_wr, sdram_addr, sdram_wdata
    );

    modport slave (
        output byte_valid, byte_data, sdram_Wait, sdram_ac,
        input  byte_ready, sdram_wr, sdram_addr, sdram_wdata
    );
endinterface

// File: rtl/audio_sdram_loader.sv
// audio_sdram_loader
//   Packs a little-endian 16-bit PCM byte stream into words and buffers them in a
//   small word FIFO. It then writes them sequentially into SDRAM from BASE_ADDR,
//   which is the region the I2S player reads. It reports completion through load_done.
//   Optional feature macro: AUDIO_LOADER_HDR_SKIP_EN. When it is defined, the first
//   HDR_BYTES accepted bytes after each start (the WAV header) are dropped.
// Ports:
//   Clk50, reset        system clock, synchronous active-high reset
//   start               one-cycle pulse that latches length_words and begins a load
//   length_words        number of 16-bit words to write
//   bus (master)        byte stream in, SDRAM write handshake out
//   busy                load in progress
//   load_done           load complete; held until the next start or reset
//   words_written       words acknowledged since start
module audio_sdram_loader #(
    parameter logic [24:0] BASE_ADDR  = 25'h80000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          HDR_BYTES  = 44
) (
    input  logic                 Clk50,
    input  logic                 reset,
    input  logic                 start,
    input  logic [23:0]          length_words,
    audio_sdram_loader_if.master bus,
    output logic                 busy,
    output logic                 load_done,
    output logic [23:0]          words_written
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_state_t;
    typedef enum logic [1:0] {WIDLE, WREQ, WACK} wr_state_t;

    ctrl_state_t   ctrl_state;
    wr_state_t     wr_state;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [23:0]   len;
    logic [23:0]   words_accepted;
    logic          byte_phase;     // 1: next payload byte completes a word
    logic [7:0]    lo_latch;
    logic          run, in_hdr, fifo_full, fifo_empty, accept, push, pop;

`ifdef AUDIO_LOADER_HDR_SKIP_EN
    localparam int HW = $clog2(HDR_BYTES + 2);
    logic [HW-1:0] hdr_cnt;
    assign in_hdr = (hdr_cnt < HW'(HDR_BYTES));
`else
    logic unused_hdr;
    assign unused_hdr = (HDR_BYTES != 0);
    assign in_hdr     = 1'b0;
`endif

    assign run        = (ctrl_state == RUN);
    assign busy       = run;
    assign load_done  = (ctrl_state == DONE);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);

    // Header bytes are always taken. Payload bytes are taken only while the FIFO has
    // room and fewer than len words have been formed. A low byte is therefore never
    // accepted unless its word is guaranteed a slot.
    assign bus.byte_ready = run & (in_hdr | (~fifo_full & (words_accepted < len)));
    assign accept         = bus.byte_valid & bus.byte_ready;
    assign push           = accept & ~in_hdr & byte_phase;
    assign pop            = (wr_state == WREQ) & bus.sdram_ac;

    // Word storage. It has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge Clk50) begin
        if (push) fifo_mem[wr_ptr] <= {bus.byte_data, lo_latch};
    end

    always_ff @(posedge Clk50) begin
        if (reset) begin
            ctrl_state      <= IDLE;
            wr_state        <= WIDLE;
            bus.sdram_wr    <= 1'b0;
            bus.sdram_addr  <= BASE_ADDR;
            bus.sdram_wdata <= '0;
            words_written   <= '0;
            len             <= '0;
            words_accepted  <= '0;
            byte_phase      <= 1'b0;
            lo_latch        <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
`ifdef AUDIO_LOADER_HDR_SKIP_EN
            hdr_cnt         <= '0;
`endif
        end else begin
            // byte intake
`ifdef AUDIO_LOADER_HDR_SKIP_EN
            if (accept && in_hdr) hdr_cnt <= hdr_cnt + 1'b1;
`endif
            if (accept && !in_hdr) begin
                if (!byte_phase) begin
                    lo_latch <= bus.byte_data;
                end else begin
                    wr_ptr         <= wr_ptr + 1'b1;
                    words_accepted <= words_accepted + 24'd1;
                end
                byte_phase <= ~byte_phase;
            end

            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;

            // Write FSM. Wait only gates starting a request; an issued request holds.
            case (wr_state)
                WIDLE: if (!fifo_empty && !bus.sdram_Wait) begin
                    wr_state        <= WREQ;
                    bus.sdram_wr    <= 1'b1;
                    bus.sdram_wdata <= fifo_mem[rd_ptr];
                end
                WREQ: if (bus.sdram_ac) begin
                    wr_state       <= WACK;
                    bus.sdram_wr   <= 1'b0;
                    rd_ptr         <= rd_ptr + 1'b1;
                    bus.sdram_addr <= bus.sdram_addr + 25'd1;
                    words_written  <= words_written + 24'd1;
                end
                WACK: if (!bus.sdram_ac) wr_state <= WIDLE;
                default: wr_state <= WIDLE;
            endcase

            // Control FSM. It is placed last so that the flush on start overrides
            // the updates above.
            case (ctrl_state)
                RUN: if (words_written == len && fifo_empty && wr_state == WIDLE)
                    ctrl_state <= DONE;
                IDLE, DONE: if (start) begin
                    ctrl_state     <= RUN;
                    len            <= length_words;
                    words_written  <= '0;
                    words_accepted <= '0;
                    byte_phase     <= 1'b0;
                    lo_latch       <= '0;
                    wr_ptr         <= '0;
                    rd_ptr         <= '0;
                    fifo_cnt       <= '0;
                    bus.sdram_addr <= BASE_ADDR;
`ifdef AUDIO_LOADER_HDR_SKIP_EN
                    hdr_cnt        <= '0;
`endif
                end
                default: ctrl_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_sdram_loader.sv
// Testbench for audio_sdram_loader. It uses a queue-based reference model and a
// per-cycle compare, plus literal expectations for the directed scenarios.
module tb_audio_sdram_loader;
    localparam logic [24:0] BASE  = 25'h80000;
    localparam int          DEPTH = 16;
`ifdef AUDIO_LOADER_HDR_SKIP_EN
    localparam int HDR  = 44;
    localparam int HDRB = HDR;
`else
    localparam int HDRB = 0;
`endif

    logic        Clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] length_words = '0;
    logic        busy, load_done;
    logic [23:0] words_written;

    audio_sdram_loader_if bus();

    audio_sdram_loader dut (
        .Clk50(Clk50), .reset(reset), .start(start), .length_words(length_words),
        .bus(bus), .busy(busy), .load_done(load_done), .words_written(words_written)
    );

    always #10 Clk50 = ~Clk50;

    int checks = 0, failures = 0;
    bit chk_en = 0, ac_en = 1, ac_rand = 0, wait_rand = 0, wait_force = 0, valid_rand = 0;
    logic rdy_s = 0, rst_s = 1;
    logic [7:0]  src_q[$];
    int          taken = 0, wr_cycles = 0;
    logic [15:0] log_d[$];
    logic [24:0] log_a[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk50); #1;
    endtask

    // ---------------- reference model ----------------
    // Spec-level view: a queue of packed words awaiting write, plus the request/ack
    // phase of the single outstanding SDRAM write.
    bit          m_run = 0, m_done = 0, m_req = 0, m_ackw = 0, m_half = 0;
    logic [23:0] m_len = 0, m_acc = 0, m_ww = 0;
    logic [7:0]  m_lo = 0;
    int          m_hdr = 0;
    logic [24:0] m_addr = BASE;
    logic [15:0] m_wdata = 0;
    logic [15:0] q[$];

    function automatic bit m_hdr_on();
`ifdef AUDIO_LOADER_HDR_SKIP_EN
        return m_hdr < HDR;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_br();
        return m_run && (m_hdr_on() || (q.size() < DEPTH && m_acc < m_len));
    endfunction

    task automatic model_step();
        bit br, idle0;
        int sz0;
        logic [23:0] ww0;
        if (reset) begin
            m_run = 0; m_done = 0; m_req = 0; m_ackw = 0; m_half = 0;
            m_len = 0; m_acc = 0; m_ww = 0; m_lo = 0; m_hdr = 0;
            m_addr = BASE; m_wdata = 0; q.delete();
            return;
        end
        br = m_br(); sz0 = q.size(); idle0 = !m_req && !m_ackw; ww0 = m_ww;
        if (bus.byte_valid && br) begin
            if (m_hdr_on()) m_hdr++;
            else if (!m_half) begin m_lo = bus.byte_data; m_half = 1; end
            else begin q.push_back({bus.byte_data, m_lo}); m_half = 0; m_acc++; end
        end
        if (m_req) begin
            if (bus.sdram_ac) begin
                void'(q.pop_front()); m_req = 0; m_ackw = 1; m_addr++; m_ww++;
            end
        end else if (m_ackw) begin
            if (!bus.sdram_ac) m_ackw = 0;
        end else if (sz0 != 0 && !bus.sdram_Wait) begin
            m_req = 1; m_wdata = q[0];
        end
        if (m_run) begin
            if (ww0 == m_len && sz0 == 0 && idle0) begin m_run = 0; m_done = 1; end
        end else if (start) begin
            m_run = 1; m_done = 0; m_len = length_words; m_acc = 0; m_half = 0;
            m_lo = 0; m_hdr = 0; q.delete(); m_addr = BASE; m_ww = 0;
        end
    endtask

    initial forever begin
        @(posedge Clk50);
        model_step();
    end

    // ---------------- compare / log (negedge) ----------------
    initial forever begin
        @(negedge Clk50);
        rdy_s = bus.byte_ready;
        rst_s = reset;
        if (bus.sdram_wr) wr_cycles++;
        if (bus.sdram_wr && bus.sdram_ac && !reset) begin
            log_d.push_back(bus.sdram_wdata);
            log_a.push_back(bus.sdram_addr);
        end
        if (chk_en) begin
            cmp("byte_ready", 32'(bus.byte_ready), 32'(m_br()));
            cmp("sdram_wr", 32'(bus.sdram_wr), 32'(m_req));
            cmp("sdram_addr", 32'(bus.sdram_addr), 32'(m_addr));
            cmp("sdram_wdata", 32'(bus.sdram_wdata), 32'(m_wdata));
            cmp("busy", 32'(busy), 32'(m_run));
            cmp("load_done", 32'(load_done), 32'(m_done));
            cmp("words_written", 32'(words_written), 32'(m_ww));
        end
    end

    // ---------------- stimulus processes ----------------
    initial begin
        bus.byte_valid = 0; bus.byte_data = 0;
        forever begin
            tick();
            if (bus.byte_valid && rdy_s && !rst_s && src_q.size() > 0) begin
                void'(src_q.pop_front()); taken++;
            end
            if (src_q.size() > 0 && (!valid_rand || $urandom_range(0, 3) != 0)) begin
                bus.byte_valid = 1; bus.byte_data = src_q[0];
            end else begin
                bus.byte_valid = 0;
            end
        end
    end

    initial begin
        bus.sdram_Wait = 0;
        forever begin
            tick();
            bus.sdram_Wait = wait_force | (wait_rand && $urandom_range(0, 2) == 0);
        end
    end

    initial begin
        bus.sdram_ac = 0;
        forever begin
            tick();
            if (bus.sdram_ac) bus.sdram_ac = 0;
            else if (ac_en && bus.sdram_wr && (!ac_rand || $urandom_range(0, 2) == 0))
                bus.sdram_ac = 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic clear_log();
        log_d.delete(); log_a.delete(); wr_cycles = 0; taken = 0;
    endtask

    task automatic feed_hdr();
        for (int i = 0; i < HDRB; i++) src_q.push_back(8'($urandom));
    endtask

    task automatic flush_src();
        src_q.delete(); tick(); tick();
    endtask

    task automatic start_load(input logic [23:0] n);
        length_words = n; start = 1; tick(); start = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!load_done && n < budget) begin tick(); n++; end
        cmp("load_done_timeout", 32'(load_done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1; src_q.delete(); tick(); reset = 0; tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, len;
        tick();
        chk_en = 1;
        cmp("rst_byte_ready", 32'(bus.byte_ready), 0);
        cmp("rst_sdram_wr", 32'(bus.sdram_wr), 0);
        cmp("rst_sdram_addr", 32'(bus.sdram_addr), 32'h80000);
        cmp("rst_sdram_wdata", 32'(bus.sdram_wdata), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_load_done", 32'(load_done), 0);
        cmp("rst_words_written", 32'(words_written), 0);
        reset = 0; tick();

        // basic load
        clear_log(); feed_hdr();
        for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
        start_load(4);
        wait_done(300);
        cmp("basic_nwr", log_d.size(), 4);
        cmp("basic_d0", 32'(log_d[0]), 32'h0201); cmp("basic_a0", 32'(log_a[0]), 32'h80000);
        cmp("basic_d1", 32'(log_d[1]), 32'h0403); cmp("basic_a1", 32'(log_a[1]), 32'h80001);
        cmp("basic_d2", 32'(log_d[2]), 32'h0605); cmp("basic_a2", 32'(log_a[2]), 32'h80002);
        cmp("basic_d3", 32'(log_d[3]), 32'h0807); cmp("basic_a3", 32'(log_a[3]), 32'h80003);
        cmp("basic_ww", 32'(words_written), 4);

        // restart from DONE
        clear_log(); feed_hdr();
        src_q.push_back(8'hA1); src_q.push_back(8'hA2); src_q.push_back(8'hA3); src_q.push_back(8'hA4);
        start_load(2);
        cmp("restart_ww0", 32'(words_written), 0);
        cmp("restart_busy", 32'(busy), 1);
        cmp("restart_done0", 32'(load_done), 0);
        wait_done(300);
        cmp("restart_a0", 32'(log_a[0]), 32'h80000);
        cmp("restart_d1", 32'(log_d[1]), 32'hA4A3);

        // len = 0
        clear_log();
        start_load(0);
        cmp("len0_busy", 32'(busy), 1);
        cmp("len0_done_n1", 32'(load_done), 0);
        tick();
        cmp("len0_done_n2", 32'(load_done), 1);
        cmp("len0_nwr", log_d.size(), 0);

        // backpressure, including a start while running that must be ignored
        wait_force = 1; clear_log(); feed_hdr();
        for (int i = 0; i < 40; i++) src_q.push_back(8'(i));
        start_load(100);
        repeat (120) tick();
        cmp("bp_taken", taken, HDRB + 32);
        cmp("bp_ready", 32'(bus.byte_ready), 0);
        cmp("bp_nowr", wr_cycles, 0);
        start_load(5);
        cmp("bp_start_ignored", 32'(busy), 1);
        wait_force = 0;
        repeat (150) tick();
        cmp("bp_nwr", log_d.size(), 20);
        for (int k = 0; k < 20; k++) begin
            cmp("bp_data", 32'(log_d[k]), 32'({8'(2*k+1), 8'(2*k)}));
            cmp("bp_addr", 32'(log_a[k]), 32'(BASE + 25'(k)));
        end
        cmp("bp_taken_all", taken, HDRB + 40);
        cmp("bp_ww", 32'(words_written), 20);
        do_reset();

        // extra bytes beyond len
        clear_log(); feed_hdr();
        for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h10 + i));
        start_load(2);
        wait_done(400);
        cmp("extra_nwr", log_d.size(), 2);
        cmp("extra_taken", taken, HDRB + 4);
        cmp("extra_ready", 32'(bus.byte_ready), 0);
        cmp("extra_d1", 32'(log_d[1]), 32'h1312);
        flush_src();

        // header skip behaviour
        clear_log();
        for (int i = 0; i < 44; i++) src_q.push_back(8'hAA);
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        start_load(1);
        wait_done(400);
        cmp("hdr_nwr", log_d.size(), 1);
`ifdef AUDIO_LOADER_HDR_SKIP_EN
        cmp("hdr_d0", 32'(log_d[0]), 32'h2211);
`else
        cmp("hdr_d0", 32'(log_d[0]), 32'hAAAA);
`endif
        cmp("hdr_a0", 32'(log_a[0]), 32'h80000);
        flush_src();

        // reset while a request is outstanding
        ac_en = 0; clear_log(); feed_hdr();
        src_q.push_back(8'h55); src_q.push_back(8'h66);
        start_load(1);
        n = 0;
        while (!bus.sdram_wr && n < 200) begin tick(); n++; end
        cmp("rstw_wr_seen", 32'(bus.sdram_wr), 1);
        reset = 1; src_q.delete(); tick();
        cmp("rstw_wr", 32'(bus.sdram_wr), 0);
        cmp("rstw_addr", 32'(bus.sdram_addr), 32'h80000);
        cmp("rstw_busy", 32'(busy), 0);
        reset = 0; ac_en = 1; tick();
        clear_log(); feed_hdr();
        src_q.push_back(8'h34); src_q.push_back(8'h12);
        start_load(1);
        wait_done(400);
        cmp("rstw_reload_d0", 32'(log_d[0]), 32'h1234);
        cmp("rstw_reload_a0", 32'(log_a[0]), 32'h80000);

        // randomized loads with Wait, ack latency and byte gaps
        ac_rand = 1; wait_rand = 1; valid_rand = 1;
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 24);
            clear_log(); feed_hdr();
            n = 2 * len + $urandom_range(0, 3);
            for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
            start_load(24'(len));
            if (r[0]) begin tick(); start_load(24'(len + 3)); end
            wait_done(4000);
            cmp("rand_ww", 32'(words_written), 32'(len));
            cmp("rand_nwr", log_d.size(), len);
            flush_src();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
